scan_chain_ctrl: RTL and testbench

Sequencer for one scan chain of scan flip-flops with asynchronous set/reset that share one clock. It accepts a parallel test pattern, shifts it into the chain, pulses one capture cycle, shifts the captured response out, and returns it in parallel over a valid/ready handshake. It sits between the on-chip test access logic and the chain's SE/SI/SO pins. Optionally, it also drives the chain's asynchronous reset to clear the chain before loading.

---
 rtl/scan_ctrl_pkg.sv | 13 +
 rtl/scan_ctrl_shreg.sv | 25 ++
 rtl/scan_chain_ctrl.sv | 143 ++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/scan_ctrl_pkg.sv
// Shared definitions for the scan chain sequencer: FSM state type with fixed encoding.
package scan_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        LOAD    = 3'd2,
        CAPTURE = 3'd3,
        UNLOAD  = 3'd4,
        RESP    = 3'd5
    } scan_state_e;

endpackage

// File: rtl/scan_ctrl_shreg.sv
// Shift register with parallel load, MSB-out / LSB-in serial shift (q[WIDTH-1] is the serial output).
module scan_ctrl_shreg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses <= so every register samples pre-edge values, whatever the block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], din};
        end
    end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: load pattern, capture once, unload response, valid/ready hand-off.
// Optional chain clear cycle before LOAD when SCAN_CTRL_INIT_EN is defined.
module scan_chain_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 32,
    parameter int CNT_W     = $clog2(CHAIN_LEN)
) (
    input  logic                 CLK,
    input  logic                 RSTB,
    input  logic                 start,
    output logic                 start_ready,
    input  logic [CHAIN_LEN-1:0] pat_in,
    input  logic                 abort,
    output logic                 scan_se,
    output logic                 scan_si,
    input  logic                 scan_so,
    output logic                 chain_rstb,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [CHAIN_LEN-1:0] resp_data,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    scan_state_e          state;
    logic [CNT_W-1:0]     cnt;
    logic [CHAIN_LEN-1:0] pat_q;
    logic                 kill;

    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign kill        = abort && busy;

    scan_ctrl_shreg #(.WIDTH(CHAIN_LEN)) u_pat (
        .clk      (CLK),
        .rst_n    (RSTB),
        .load     (state == IDLE && start),
        .load_val (pat_in),
        .shift    (state == LOAD),
        .din      (1'b0),
        .q        (pat_q)
    );

    // Each UNLOAD edge captures SO before the chain moves; an abort freezes the partial response.
    scan_ctrl_shreg #(.WIDTH(CHAIN_LEN)) u_resp (
        .clk      (CLK),
        .rst_n    (RSTB),
        .load     (1'b0),
        .load_val ('0),
        .shift    (state == UNLOAD && !abort),
        .din      (scan_so),
        .q        (resp_data)
    );

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            state      <= IDLE;
            cnt        <= '0;
            scan_se    <= 1'b0;
            scan_si    <= 1'b0;
            resp_valid <= 1'b0;
        end else if (kill) begin
            state      <= IDLE;
            cnt        <= '0;
            scan_se    <= 1'b0;
            scan_si    <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= '0;
`ifdef SCAN_CTRL_INIT_EN
                        state <= INIT;
`else
                        state   <= LOAD;
                        scan_se <= 1'b1;
                        scan_si <= pat_in[CHAIN_LEN-1];
`endif
                    end
                end
                INIT: begin
                    state   <= LOAD;
                    scan_se <= 1'b1;
                    scan_si <= pat_q[CHAIN_LEN-1];
                end
                // scan_si is registered, so it is fed one bit ahead of the pattern shift.
                LOAD: begin
                    if (cnt == LAST) begin
                        state   <= CAPTURE;
                        cnt     <= '0;
                        scan_se <= 1'b0;
                        scan_si <= 1'b0;
                    end else begin
                        cnt     <= cnt + CNT_W'(1);
                        scan_si <= pat_q[CHAIN_LEN-2];
                    end
                end
                CAPTURE: begin
                    state   <= UNLOAD;
                    cnt     <= '0;
                    scan_se <= 1'b1;
                    scan_si <= 1'b0;
                end
                UNLOAD: begin
                    if (cnt == LAST) begin
                        state      <= RESP;
                        cnt        <= '0;
                        scan_se    <= 1'b0;
                        resp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SCAN_CTRL_INIT_EN
    // Low for exactly the INIT cycle: set on the accept edge, released on the next one.
    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            chain_rstb <= 1'b1;
        end else begin
            chain_rstb <= !(state == IDLE && start);
        end
    end
`else
    assign chain_rstb = 1'b1;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Randomized bench for scan_chain_ctrl (CHAIN_LEN=8) against a timeline model and an 8-flop chain model.
module tb_scan_chain_ctrl;

    localparam int N = 8;
`ifdef SCAN_CTRL_INIT_EN
    localparam int OFF = 1;
`else
    localparam int OFF = 0;
`endif
    localparam int LAT = 2 * N + 1 + OFF;
    localparam logic [5:0] IDLE_VEC = 6'b100001;

    logic         clk = 1'b0;
    logic         rstb;
    logic         start;
    logic         start_ready;
    logic [N-1:0] pat_in;
    logic         abort;
    logic         scan_se;
    logic         scan_si;
    logic         scan_so;
    logic         chain_rstb;
    logic         resp_valid;
    logic         resp_ready;
    logic [N-1:0] resp_data;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Chain model: flop 0 next to SI, flop N-1 drives SO.
    logic [N-1:0] chain;
    int           d_mode;
    logic [N-1:0] d_const;
    logic         preset;

    always #5 clk = ~clk;

    scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
        .CLK         (clk),
        .RSTB        (rstb),
        .start       (start),
        .start_ready (start_ready),
        .pat_in      (pat_in),
        .abort       (abort),
        .scan_se     (scan_se),
        .scan_si     (scan_si),
        .scan_so     (scan_so),
        .chain_rstb  (chain_rstb),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .busy        (busy)
    );

    assign scan_so = chain[N-1];

    always @(posedge clk or negedge chain_rstb) begin
        if (!chain_rstb)     chain <= '0;
        else if (preset)     chain <= '1;
        else if (scan_se)    chain <= {chain[N-2:0], scan_si};
        else if (d_mode == 0) chain <= d_const;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] out_vec();
        return {start_ready, busy, scan_se, scan_si, resp_valid, chain_rstb};
    endfunction

    // Expected {start_ready, busy, se, si, valid, chain_rstb} t cycles after the accept edge.
    function automatic logic [5:0] exp_vec(input int t, input logic [N-1:0] p);
        logic se, si, rv, cr;
        se = 1'b0; si = 1'b0; rv = 1'b0; cr = 1'b1;
        if (t < OFF) begin
            cr = 1'b0;
        end else if (t < OFF + N) begin
            se = 1'b1;
            si = p[N-1-(t-OFF)];
        end else if (t > OFF + N && t < LAT) begin
            se = 1'b1;
        end else if (t >= LAT) begin
            rv = 1'b1;
        end
        return {1'b0, 1'b1, se, si, rv, cr};
    endfunction

    // dmode 0: functional D tied to dval; dmode 1: D = Q (capture keeps the loaded pattern).
    task automatic run(input logic [N-1:0] pat, input int dmode, input logic [N-1:0] dval,
                       input int stall, input int abort_at, input int rst_at, input bit abort_on_start);
        logic [N-1:0] exp_resp;
        d_mode   = dmode;
        d_const  = dval;
        exp_resp = (dmode == 0) ? dval : pat;
        pat_in   = pat;
        start    = 1'b1;
        abort    = abort_on_start;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int t = 0; t <= LAT + stall; t++) begin
            check("cycle", 32'(out_vec()), 32'(exp_vec(t, pat)));
            if (t >= LAT) check("resp_data", 32'(resp_data), 32'(exp_resp));
            if (t == abort_at || t == rst_at) begin
                if (t == abort_at) abort = 1'b1;
                else               rstb  = 1'b0;
                tick();
                abort = 1'b0;
                rstb  = 1'b1;
                check("after_abort_rst", 32'(out_vec()), 32'(IDLE_VEC));
                if (t == rst_at) check("rst_data", 32'(resp_data), 32'h0);
                return;
            end
            if (t == LAT + stall) resp_ready = 1'b1;
            tick();
        end
        resp_ready = 1'b0;
        check("handshake", 32'(out_vec()), 32'(IDLE_VEC));
    endtask

    initial begin
        rstb       = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        resp_ready = 1'b0;
        pat_in     = '0;
        d_mode     = 1;
        d_const    = '0;
        preset     = 1'b0;
        tick();
        tick();
        rstb = 1'b1;
        check("reset_vec", 32'(out_vec()), 32'(IDLE_VEC));
        check("reset_data", 32'(resp_data), 32'h0);

        // Abort alone in IDLE is ignored.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort", 32'(out_vec()), 32'(IDLE_VEC));

        run(8'hA5, 0, 8'h3C, 0, -1, -1, 1'b0);
        run(8'h81, 1, 8'h00, 0, -1, -1, 1'b0);
        run(8'h5A, 0, 8'hC3, 10, -1, -1, 1'b0);
        run(8'h77, 1, 8'h00, 0, OFF + N + 1 + 3, -1, 1'b0);
        run(8'h0F, 1, 8'h00, 0, -1, -1, 1'b0);
        run(8'h66, 0, 8'h99, 0, -1, OFF + 3, 1'b0);
        run(8'h3E, 1, 8'h00, 2, LAT + 1, -1, 1'b0);
        run(8'hC9, 0, 8'h2B, 0, -1, -1, 1'b1);

        // Chain preset to all ones; with the clear cycle or a full load the response is the pattern.
        preset = 1'b1;
        tick();
        preset = 1'b0;
        run(8'h00, 1, 8'h00, 0, -1, -1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            int ab;
            int st;
            st = int'($urandom_range(0, 5));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LAT + st)) : -1;
            run(N'($urandom), int'($urandom_range(0, 1)), N'($urandom), st, ab, -1, 1'b0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
